// File: rtl/vga_rx_pkg.sv
// Shared timing defaults, receiver state encoding and pixel type for the VGA sync receiver.
package vga_rx_pkg;

   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BACK = 48;
   localparam int DEF_H_ACT  = 640;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BACK = 31;
   localparam int DEF_V_ACT  = 480;

   localparam logic [11:0] CNT_MAX = 12'hFFF;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_ALIGN,
      ST_RUN
   } rx_state_e;

   typedef logic [23:0] pixel_t;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == CNT_MAX) ? v : v + 12'd1;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input, normalises it to active-high and flags its assertion edge.
module vga_sync_edge #(
   parameter int SYNC_POL = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_i,
   output logic rise_o
);

   logic norm;
   logic level_q;

   assign norm = (SYNC_POL != 0) ? sync_i : ~sync_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
      end else begin
         level_q <= norm;
      end
   end

   // High in the cycle whose clock edge moves the registered level 0->1, so
   // counters loaded by it line up with the pixel captured on that same edge.
   assign rise_o = norm & ~level_q;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel coordinates from h_sync/v_sync and captures active pixels.
// Optional VGA_RX_MEASURE_EN: lock is based on measured line/frame totals instead of FSM state.
module vga_sync_rx
   import vga_rx_pkg::*;
#(
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int H_ACT    = DEF_H_ACT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACT    = DEF_V_ACT,
   parameter int SYNC_POL = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [23:0] rgb_in,
   output logic        pix_valid,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic [23:0] pix_rgb,
   output logic        frame_start,
   output logic        frame_done,
   output logic        locked
);

   localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_LAST  = 12'(H_SYNC + H_BACK + H_ACT - 1);
   localparam logic [11:0] V_START = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] V_LAST  = 12'(V_SYNC + V_BACK + V_ACT - 1);
   localparam logic [11:0] X_LAST  = 12'(H_ACT - 1);
   localparam logic [11:0] Y_LAST  = 12'(V_ACT - 1);

   logic [1:0]  sync_in;
   logic [1:0]  sync_rise;
   logic        hs_rise;
   logic        vs_rise;
   pixel_t      rgb_q;
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic        vs_pend_q, vs_pend_d;
   logic        v_load;
   rx_state_e   state_q, state_d;
   logic        active;
   logic [11:0] x_off, y_off;
   logic        pix_valid_q, frame_start_q, frame_done_q, locked_q;
   logic [11:0] pix_x_q, pix_y_q;
   pixel_t      pix_rgb_q;

   assign sync_in = {v_sync, h_sync};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_edge (
            .clk    (clk),
            .rst    (rst),
            .sync_i (sync_in[gi]),
            .rise_o (sync_rise[gi])
         );
      end
   endgenerate

   assign hs_rise = sync_rise[0];
   assign vs_rise = sync_rise[1];

   // A vsync edge arms the row reset; the first hsync edge at or after it applies it.
   assign v_load = hs_rise & (vs_pend_q | vs_rise);

   always_comb begin
      h_cnt_d   = hs_rise ? 12'd0 : sat_inc(h_cnt_q);
      v_cnt_d   = v_cnt_q;
      vs_pend_d = vs_pend_q;
      if (v_load) begin
         v_cnt_d   = 12'd0;
         vs_pend_d = 1'b0;
      end else begin
         if (hs_rise) v_cnt_d = sat_inc(v_cnt_q);
         if (vs_rise) vs_pend_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEARCH: if (vs_rise) state_d = v_load ? ST_RUN : ST_ALIGN;
         ST_ALIGN:  if (v_load)  state_d = ST_RUN;
         ST_RUN:    state_d = ST_RUN;
         default:   state_d = ST_SEARCH;
      endcase
      if (h_cnt_q == CNT_MAX) state_d = ST_SEARCH;
   end

   assign x_off  = h_cnt_q - H_START;
   assign y_off  = v_cnt_q - V_START;
   assign active = (state_q == ST_RUN)
                 && (h_cnt_q >= H_START) && (h_cnt_q <= H_LAST)
                 && (v_cnt_q >= V_START) && (v_cnt_q <= V_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q         <= '0;
         h_cnt_q       <= 12'd0;
         v_cnt_q       <= 12'd0;
         vs_pend_q     <= 1'b0;
         state_q       <= ST_SEARCH;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= 12'd0;
         pix_y_q       <= 12'd0;
         pix_rgb_q     <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         rgb_q         <= rgb_in;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         vs_pend_q     <= vs_pend_d;
         state_q       <= state_d;
         pix_valid_q   <= active;
         pix_x_q       <= active ? x_off : 12'd0;
         pix_y_q       <= active ? y_off : 12'd0;
         pix_rgb_q     <= active ? rgb_q : '0;
         frame_start_q <= active && (x_off == 12'd0) && (y_off == 12'd0);
         frame_done_q  <= active && (x_off == X_LAST) && (y_off == Y_LAST);
      end
   end

`ifdef VGA_RX_MEASURE_EN
   logic [11:0] h_total_q, v_total_q;
   logic [11:0] h_meas, v_meas;
   logic        frame_bad_q, h_mis, v_mis;

   assign h_meas = h_cnt_q + 12'd1;
   assign v_meas = v_cnt_q + 12'd1;
   assign h_mis  = hs_rise && (h_meas != h_total_q);
   assign v_mis  = v_meas != v_total_q;

   // A frame counts as good when every line and the frame length repeat the previous ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_total_q   <= 12'd0;
         v_total_q   <= 12'd0;
         frame_bad_q <= 1'b1;
         locked_q    <= 1'b0;
      end else begin
         if (hs_rise) h_total_q <= h_meas;
         if (vs_rise) v_total_q <= v_meas;
         if (state_d == ST_SEARCH) begin
            frame_bad_q <= 1'b1;
            locked_q    <= 1'b0;
         end else if (vs_rise) begin
            locked_q    <= !(frame_bad_q || h_mis || v_mis);
            frame_bad_q <= 1'b0;
         end else if (h_mis) begin
            frame_bad_q <= 1'b1;
            locked_q    <= 1'b0;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= (state_d == ST_RUN);
      end
   end
`endif

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_rgb     = pix_rgb_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a reduced 18x10 timing (8x4 active), active-low syncs.
module tb_vga_sync_rx;

   localparam int HS = 4, HB = 3, HA = 8, HF = 3, HT = HS + HB + HA + HF;
   localparam int VS = 2, VB = 2, VA = 4, VF = 2, VT = VS + VB + VA + VF;

   logic        clk = 1'b0;
   logic        rst;
   logic        h_sync, v_sync;
   logic [23:0] rgb_in;
   logic        pix_valid, frame_start, frame_done, locked;
   logic [11:0] pix_x, pix_y;
   logic [23:0] pix_rgb;

   int          total = 0;
   int          bad   = 0;
   int          nvalid, nfs, nfd;
   bit          run;
   logic [50:0] prev_exp;

   always #5 clk = ~clk;

   vga_sync_rx #(
      .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA),
      .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA),
      .SYNC_POL(0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .h_sync      (h_sync),
      .v_sync      (v_sync),
      .rgb_in      (rgb_in),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_rgb     (pix_rgb),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .locked      (locked)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, then compare outputs against the input of the previous clock.
   task automatic tick(input logic hs_n, input logic vs_n, input logic [23:0] rgb,
                       input bit act, input logic [11:0] ex, input logic [11:0] ey);
      logic [50:0] cur;
      logic [50:0] obs;
      h_sync = hs_n;
      v_sync = vs_n;
      rgb_in = rgb;
      cur = (act && run && !rst)
          ? {1'b1, ex, ey, rgb, (ex == 12'd0) && (ey == 12'd0),
             (ex == 12'(HA - 1)) && (ey == 12'(VA - 1))}
          : '0;
      @(posedge clk);
      #1;
      obs = {pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done};
      check("pix", 64'(obs), rst ? 64'd0 : 64'(prev_exp));
      prev_exp = cur;
      nvalid += int'(pix_valid);
      nfs    += int'(frame_start);
      nfd    += int'(frame_done);
   endtask

   task automatic line(input int l, input int c0, input int c1, input bit vs_on);
      bit          act;
      logic [11:0] ex, ey;
      for (int c = c0; c <= c1; c++) begin
         act = (c >= HS + HB) && (c < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
         ex  = 12'(c - HS - HB);
         ey  = 12'(l - VS - VB);
         tick(!(c < HS), !vs_on, act ? {ey, ex} : 24'hFFFFFF, act,
              act ? ex : 12'd0, act ? ey : 12'd0);
      end
   endtask

   task automatic frame(input int nl, input int short_l);
      for (int l = 0; l < nl; l++) begin
         line(l, 0, (l == short_l) ? 9 : HT - 1, l < VS);
      end
   endtask

   task automatic clr_counts();
      nvalid = 0;
      nfs    = 0;
      nfd    = 0;
   endtask

   task automatic frame_counts(input int e_valid, input int e_fs, input int e_fd);
      check("valid_count", 64'(nvalid), 64'(e_valid));
      check("start_count", 64'(nfs), 64'(e_fs));
      check("done_count", 64'(nfd), 64'(e_fd));
   endtask

   initial begin
      rst      = 1'b1;
      h_sync   = 1'b1;
      v_sync   = 1'b1;
      rgb_in   = '0;
      run      = 1'b0;
      prev_exp = '0;
      clr_counts();

      // Reset with non-zero pixel data on the input.
      repeat (3) tick(1'b1, 1'b1, 24'hABCDEF, 1'b0, 12'd0, 12'd0);
      check("reset_locked", 64'(locked), 64'd0);
      rst = 1'b0;
      repeat (4) tick(1'b1, 1'b1, 24'hFFFFFF, 1'b0, 12'd0, 12'd0);
      check("idle_locked", 64'(locked), 64'd0);

      // Two standard frames, captured from the first vsync after reset.
      run = 1'b1;
      for (int f = 0; f < 2; f++) begin
         clr_counts();
         frame(VT, -1);
         frame_counts(HA * VA, 1, 1);
         check("run_locked", 64'(locked), 64'd1);
      end

      // Early vsync after 6 lines, with line 4 cut short after 10 clocks.
      clr_counts();
      frame(6, 4);
      frame_counts(3 + HA, 1, 0);
      clr_counts();
      frame(VT, -1);
      frame_counts(HA * VA, 1, 1);

      // hsync stuck inactive on line 5 long enough to saturate the line counter.
      clr_counts();
      for (int l = 0; l < 5; l++) line(l, 0, HT - 1, l < VS);
      line(5, 0, 4099, 1'b0);
      run = 1'b0;
      check("timeout_locked", 64'(locked), 64'd0);
      for (int l = 6; l < VT; l++) line(l, 0, HT - 1, 1'b0);
      frame_counts(2 * HA, 1, 0);
      check("search_locked", 64'(locked), 64'd0);
      run = 1'b1;
      clr_counts();
      frame(VT, -1);
      frame_counts(HA * VA, 1, 1);

      // Reset pulse in the middle of active row 1.
      clr_counts();
      for (int l = 0; l < 5; l++) line(l, 0, HT - 1, l < VS);
      line(5, 0, 9, 1'b0);
      rst = 1'b1;
      run = 1'b0;
      line(5, 10, 10, 1'b0);
      rst = 1'b0;
      check("rst_locked", 64'(locked), 64'd0);
      line(5, 11, HT - 1, 1'b0);
      for (int l = 6; l < VT; l++) line(l, 0, HT - 1, 1'b0);
      frame_counts(HA + 2, 1, 0);
      run = 1'b1;
      clr_counts();
      frame(VT, -1);
      frame_counts(HA * VA, 1, 1);
      check("relock", 64'(locked), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
